// File: rtl/axi_device_bridge.sv
// Aquila uncached device port to single-outstanding AXI4-Lite master.
// Maps error responses, forces completion on timeout and pends one request.
module axi_device_bridge #(
  parameter int XLEN = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [XLEN-1:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dev_strobe_i,
  input  logic [XLEN-1:0]       dev_addr_i,
  input  logic                  dev_rw_i,
  input  logic [XLEN/8-1:0]     dev_byte_enable_i,
  input  logic [XLEN-1:0]       dev_data_i,
  output logic                  dev_data_ready_o,
  output logic [XLEN-1:0]       dev_data_o,
  output logic                  dev_err_o,
  output logic [ADDR_WIDTH-1:0] m_awaddr_o,
  output logic [2:0]            m_awprot_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [XLEN-1:0]       m_wdata_o,
  output logic [XLEN/8-1:0]     m_wstrb_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic [1:0]            m_bresp_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic [2:0]            m_arprot_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [XLEN-1:0]       m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o
);

  localparam int BW = XLEN / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, paddr_q, paddr_d, l_addr;
  logic [BW-1:0] be_q, be_d, pbe_q, pbe_d, l_be;
  logic [XLEN-1:0] wdata_q, wdata_d, pdata_q, pdata_d, l_data;
  logic [XLEN-1:0] data_q, data_d;
  logic prw_q, prw_d, pv_q, pv_d, l_rw;
  logic aw_q, aw_d, w_q, w_d, ar_q, ar_d, b_q, b_d, r_q, r_d;
  logic rdy_q, rdy_d, err_q, err_d, orphan_q, orphan_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic resp_hs, busy;
  logic unused_bits;

  assign unused_bits = ^{m_bresp_i[0], m_rresp_i[0],
                         dev_addr_i[XLEN-1:ADDR_WIDTH]};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    aw_d     = aw_q;
    w_d      = w_q;
    ar_d     = ar_q;
    b_d      = b_q;
    r_d      = r_q;
    rdy_d    = 1'b0;
    err_d    = err_q;
    data_d   = data_q;
    orphan_d = orphan_q;
    cnt_d    = cnt_q;
    pv_d     = pv_q;
    prw_d    = prw_q;
    paddr_d  = paddr_q;
    pbe_d    = pbe_q;
    pdata_d  = pdata_q;
    busy     = (state_q != IDLE);
    resp_hs  = (state_q == WR_RESP && m_bvalid_i) ||
               (state_q == RD_RESP && m_rvalid_i);
    // a pended request always issues ahead of a fresh strobe
    l_rw   = pv_q ? prw_q   : dev_rw_i;
    l_addr = pv_q ? paddr_q : dev_addr_i[ADDR_WIDTH-1:0];
    l_be   = pv_q ? pbe_q   : dev_byte_enable_i;
    l_data = pv_q ? pdata_q : dev_data_i;

    unique case (state_q)
      IDLE: begin
        if (pv_q || dev_strobe_i) begin
          pv_d     = 1'b0;
          addr_d   = l_addr;
          be_d     = l_be;
          wdata_d  = l_data;
          cnt_d    = '0;
          orphan_d = 1'b0;
          if (l_rw) begin
            aw_d    = 1'b1;
            w_d     = 1'b1;
            state_d = WR_REQ;
          end else begin
            ar_d    = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (m_awready_i) aw_d = 1'b0;
        if (m_wready_i) w_d = 1'b0;
        if (!aw_d && !w_d) begin
          b_d     = 1'b1;
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_bvalid_i) begin
          b_d      = 1'b0;
          orphan_d = 1'b0;
          state_d  = IDLE;
          if (!orphan_q) begin
            rdy_d = 1'b1;
            err_d = m_bresp_i[1];
          end
        end
      end
      RD_REQ: begin
        if (m_arready_i) begin
          ar_d    = 1'b0;
          r_d     = 1'b1;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_rvalid_i) begin
          r_d      = 1'b0;
          orphan_d = 1'b0;
          state_d  = IDLE;
          if (!orphan_q) begin
            rdy_d  = 1'b1;
            err_d  = m_rresp_i[1];
            data_d = m_rresp_i[1] ? ERR_DATA : m_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy && orphan_q && dev_strobe_i && !pv_q) begin
      pv_d    = 1'b1;
      prw_d   = dev_rw_i;
      paddr_d = dev_addr_i[ADDR_WIDTH-1:0];
      pbe_d   = dev_byte_enable_i;
      pdata_d = dev_data_i;
    end

    // a response landing in the expiry cycle completes normally
    if (TIMEOUT_CYCLES != 0 && busy) begin
      if (cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
      if (!orphan_q && !resp_hs && cnt_q == TO_MAX - 1'b1) begin
        rdy_d    = 1'b1;
        err_d    = 1'b1;
        data_d   = ERR_DATA;
        orphan_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      ar_q     <= 1'b0;
      b_q      <= 1'b0;
      r_q      <= 1'b0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      orphan_q <= 1'b0;
      cnt_q    <= '0;
      pv_q     <= 1'b0;
      prw_q    <= 1'b0;
      paddr_q  <= '0;
      pbe_q    <= '0;
      pdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      aw_q     <= aw_d;
      w_q      <= w_d;
      ar_q     <= ar_d;
      b_q      <= b_d;
      r_q      <= r_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      data_q   <= data_d;
      orphan_q <= orphan_d;
      cnt_q    <= cnt_d;
      pv_q     <= pv_d;
      prw_q    <= prw_d;
      paddr_q  <= paddr_d;
      pbe_q    <= pbe_d;
      pdata_q  <= pdata_d;
    end
  end

  assign dev_data_ready_o = rdy_q;
  assign dev_data_o       = data_q;
  assign dev_err_o        = err_q;
  assign m_awaddr_o       = addr_q;
  assign m_awprot_o       = 3'b000;
  assign m_awvalid_o      = aw_q;
  assign m_wdata_o        = wdata_q;
  assign m_wstrb_o        = be_q;
  assign m_wvalid_o       = w_q;
  assign m_bready_o       = b_q;
  assign m_araddr_o       = addr_q;
  assign m_arprot_o       = 3'b000;
  assign m_arvalid_o      = ar_q;
  assign m_rready_o       = r_q;

endmodule

// File: tb/tb_axi_device_bridge.sv
// Directed bench for axi_device_bridge: vector table plus timeout,
// pending and mid-transaction reset sequences.
module tb_axi_device_bridge;

  localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        dev_strobe_i;
  logic [63:0] dev_addr_i;
  logic        dev_rw_i;
  logic [7:0]  dev_byte_enable_i;
  logic [63:0] dev_data_i;
  logic        dev_data_ready_o;
  logic [63:0] dev_data_o;
  logic        dev_err_o;
  logic [31:0] m_awaddr_o;
  logic [2:0]  m_awprot_o;
  logic        m_awvalid_o;
  logic        m_awready_i;
  logic [63:0] m_wdata_o;
  logic [7:0]  m_wstrb_o;
  logic        m_wvalid_o;
  logic        m_wready_i;
  logic [1:0]  m_bresp_i;
  logic        m_bvalid_i;
  logic        m_bready_o;
  logic [31:0] m_araddr_o;
  logic [2:0]  m_arprot_o;
  logic        m_arvalid_o;
  logic        m_arready_i;
  logic [63:0] m_rdata_i;
  logic [1:0]  m_rresp_i;
  logic        m_rvalid_i;
  logic        m_rready_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    int          rsp_dly;
    logic [1:0]  resp;
    logic [63:0] rdata;
    int          exp_rdy;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_aw;
    int          exp_w;
    int          exp_ar;
  } vec_t;

  vec_t vt[9];

  axi_device_bridge #(
    .XLEN(64),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA(ERR)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .dev_strobe_i(dev_strobe_i),
    .dev_addr_i(dev_addr_i),
    .dev_rw_i(dev_rw_i),
    .dev_byte_enable_i(dev_byte_enable_i),
    .dev_data_i(dev_data_i),
    .dev_data_ready_o(dev_data_ready_o),
    .dev_data_o(dev_data_o),
    .dev_err_o(dev_err_o),
    .m_awaddr_o(m_awaddr_o),
    .m_awprot_o(m_awprot_o),
    .m_awvalid_o(m_awvalid_o),
    .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o),
    .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i),
    .m_bvalid_i(m_bvalid_i),
    .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o),
    .m_arprot_o(m_arprot_o),
    .m_arvalid_o(m_arvalid_o),
    .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i),
    .m_rvalid_i(m_rvalid_i),
    .m_rready_o(m_rready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle_slave();
    m_awready_i = 1'b0;
    m_wready_i  = 1'b0;
    m_arready_i = 1'b0;
    m_bvalid_i  = 1'b0;
    m_rvalid_i  = 1'b0;
    m_bresp_i   = 2'b00;
    m_rresp_i   = 2'b00;
    m_rdata_i   = '0;
  endtask

  task automatic strobe(input logic rw, input logic [31:0] a,
                        input logic [7:0] be, input logic [63:0] d);
    dev_strobe_i      = 1'b1;
    dev_rw_i          = rw;
    dev_addr_i        = {32'h0, a};
    dev_byte_enable_i = be;
    dev_data_i        = d;
    @(posedge clk); #1;
    dev_strobe_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int aw_hs, w_hs, ar_hs, rsp_hs, req_j, rdy_j, npulse;
    int awc, wc, arc;
    logic got_err;
    logic [63:0] got_data;
    string p;
    aw_hs = 0; w_hs = 0; ar_hs = 0; rsp_hs = 0; rdy_j = 0;
    npulse = 0; awc = 0; wc = 0; arc = 0;
    got_err = 1'b0; got_data = '0;
    p = $sformatf("v%0d", idx);
    strobe(v.rw, v.addr, v.be, v.wdata);
    for (int j = 1; j <= 20; j++) begin
      if (dev_data_ready_o) begin
        npulse++;
        if (rdy_j == 0) begin
          rdy_j    = j;
          got_data = dev_data_o;
          got_err  = dev_err_o;
        end
      end
      if (j == 1) begin
        if (v.rw) begin
          chk({p, "_awaddr"}, 64'(m_awaddr_o), 64'(v.addr));
          chk({p, "_wstrb"}, 64'(m_wstrb_o), 64'(v.be));
          chk({p, "_wdata"}, m_wdata_o, v.wdata);
          chk({p, "_awprot"}, 64'(m_awprot_o), 64'(0));
        end else begin
          chk({p, "_araddr"}, 64'(m_araddr_o), 64'(v.addr));
          chk({p, "_arprot"}, 64'(m_arprot_o), 64'(0));
        end
      end
      if (m_awvalid_o) awc++;
      if (m_wvalid_o) wc++;
      if (m_arvalid_o) arc++;
      req_j = v.rw ? ((aw_hs != 0 && w_hs != 0) ?
                      ((aw_hs > w_hs) ? aw_hs : w_hs) : 0) : ar_hs;
      m_awready_i = (aw_hs == 0) && (j >= v.aw_dly) && v.rw;
      m_wready_i  = (w_hs == 0) && (j >= v.w_dly) && v.rw;
      m_arready_i = (ar_hs == 0) && (j >= v.ar_dly) && !v.rw;
      m_bvalid_i  = v.rw && rsp_hs == 0 && req_j != 0 &&
                    j >= req_j + 1 + v.rsp_dly;
      m_rvalid_i  = !v.rw && rsp_hs == 0 && req_j != 0 &&
                    j >= req_j + 1 + v.rsp_dly;
      m_bresp_i   = v.resp;
      m_rresp_i   = v.resp;
      m_rdata_i   = v.rdata;
      if (m_awvalid_o && m_awready_i) aw_hs = j;
      if (m_wvalid_o && m_wready_i) w_hs = j;
      if (m_arvalid_o && m_arready_i) ar_hs = j;
      if ((m_bvalid_i && m_bready_o) || (m_rvalid_i && m_rready_o))
        rsp_hs = j;
      @(posedge clk); #1;
    end
    idle_slave();
    chk({p, "_npulse"}, 64'(npulse), 64'(1));
    chk({p, "_rdy_cycle"}, 64'(rdy_j), 64'(v.exp_rdy));
    chk({p, "_data"}, got_data, v.exp_data);
    chk({p, "_err"}, 64'(got_err), 64'(v.exp_err));
    if (v.rw) begin
      chk({p, "_aw_cycles"}, 64'(awc), 64'(v.exp_aw));
      chk({p, "_w_cycles"}, 64'(wc), 64'(v.exp_w));
    end else begin
      chk({p, "_ar_cycles"}, 64'(arc), 64'(v.exp_ar));
    end
  endtask

  initial begin
    int npulse, p1, p2;
    logic [63:0] d1, d2;
    logic e1, e2;

    //        rw    addr           be     wdata
    //        aw w ar rsp resp rdata  rdy exp_data exp_err aw w ar
    vt[0] = '{1'b1, 32'hC000_0010, 8'h0F, 64'h1122_3344_5566_7788,
              1, 1, 0, 0, 2'b00, 64'h0, 3, 64'h0, 1'b0, 1, 1, 0};
    vt[1] = '{1'b0, 32'hC000_0020, 8'h00, 64'h0,
              0, 0, 4, 0, 2'b00, 64'hCAFE, 6, 64'hCAFE, 1'b0, 0, 0, 4};
    vt[2] = '{1'b1, 32'hC000_0030, 8'hFF, 64'hAAAA_5555_AAAA_5555,
              1, 4, 0, 0, 2'b00, 64'h0, 6, 64'hCAFE, 1'b0, 1, 4, 0};
    vt[3] = '{1'b0, 32'hC000_0040, 8'h00, 64'h0,
              0, 0, 1, 0, 2'b10, 64'h1234, 3, ERR, 1'b1, 0, 0, 1};
    vt[4] = '{1'b0, 32'hC000_0048, 8'h00, 64'h0,
              0, 0, 2, 1, 2'b01, 64'hFEED_0001, 5, 64'hFEED_0001,
              1'b0, 0, 0, 2};
    vt[5] = '{1'b1, 32'hC000_0050, 8'h80, 64'h0123_4567_89AB_CDEF,
              1, 1, 0, 0, 2'b10, 64'h0, 3, 64'hFEED_0001, 1'b1, 1, 1, 0};
    vt[6] = '{1'b0, 32'hC000_0058, 8'h00, 64'h0,
              0, 0, 1, 0, 2'b11, 64'h9999, 3, ERR, 1'b1, 0, 0, 1};
    vt[7] = '{1'b1, 32'hC000_0060, 8'h3C, 64'h0F0F_0F0F_0F0F_0F0F,
              3, 2, 0, 0, 2'b00, 64'h0, 5, ERR, 1'b0, 3, 2, 0};
    vt[8] = '{1'b0, 32'hC000_0070, 8'h00, 64'h0,
              0, 0, 1, 0, 2'b00, 64'hABCD, 3, 64'hABCD, 1'b0, 0, 0, 1};

    rst_ni = 1'b0;
    dev_strobe_i = 1'b0;
    dev_rw_i = 1'b0;
    dev_addr_i = '0;
    dev_byte_enable_i = '0;
    dev_data_i = '0;
    idle_slave();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 64'({m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o,
                           m_rready_o, dev_data_ready_o, dev_err_o}), 64'(0));
    chk("rst_data", dev_data_o, 64'h0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("idle_flags", 64'({m_awvalid_o, m_wvalid_o, m_arvalid_o,
                            dev_data_ready_o}), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // timeout, pended second read, orphaned response discarded
    npulse = 0; p1 = 0; p2 = 0;
    d1 = '0; d2 = '0; e1 = 1'b0; e2 = 1'b0;
    strobe(1'b0, 32'hC000_0080, 8'h00, 64'h0);
    for (int j = 1; j <= 20; j++) begin
      if (dev_data_ready_o) begin
        npulse++;
        if (p1 == 0) begin p1 = j; d1 = dev_data_o; e1 = dev_err_o; end
        else if (p2 == 0) begin p2 = j; d2 = dev_data_o; e2 = dev_err_o; end
      end
      if (j == 12) chk("to_rready_orphan", 64'(m_rready_o), 64'(1));
      if (j == 13) begin
        chk("to_discard_data", dev_data_o, ERR);
        chk("to_ar_idle", 64'(m_arvalid_o), 64'(0));
      end
      if (j == 14) begin
        chk("to_pend_arvalid", 64'(m_arvalid_o), 64'(1));
        chk("to_pend_araddr", 64'(m_araddr_o), 64'h0000_0000_C000_0088);
      end
      m_arready_i = (j == 1) || (j == 14);
      m_rvalid_i  = (j == 12) || (j == 15);
      m_rdata_i   = (j == 12) ? 64'h5555 : 64'h7777;
      m_rresp_i   = 2'b00;
      dev_strobe_i = (j == 10);
      dev_rw_i     = 1'b0;
      dev_addr_i   = 64'hC000_0088;
      @(posedge clk); #1;
    end
    dev_strobe_i = 1'b0;
    idle_slave();
    chk("to_npulse", 64'(npulse), 64'(2));
    chk("to_p1_cycle", 64'(p1), 64'(9));
    chk("to_p1_err", 64'(e1), 64'(1));
    chk("to_p1_data", d1, ERR);
    chk("to_p2_cycle", 64'(p2), 64'(16));
    chk("to_p2_err", 64'(e2), 64'(0));
    chk("to_p2_data", d2, 64'h7777);

    // response in the expiry cycle wins over the timeout
    npulse = 0; p1 = 0; d1 = '0; e1 = 1'b1;
    strobe(1'b0, 32'hC000_0090, 8'h00, 64'h0);
    for (int j = 1; j <= 14; j++) begin
      if (dev_data_ready_o) begin
        npulse++;
        if (p1 == 0) begin p1 = j; d1 = dev_data_o; e1 = dev_err_o; end
      end
      m_arready_i = (j == 1);
      m_rvalid_i  = (j == 8);
      m_rdata_i   = 64'h8888;
      @(posedge clk); #1;
    end
    idle_slave();
    chk("race_npulse", 64'(npulse), 64'(1));
    chk("race_cycle", 64'(p1), 64'(9));
    chk("race_err", 64'(e1), 64'(0));
    chk("race_data", d1, 64'h8888);

    // asynchronous reset while waiting in RD_RESP
    strobe(1'b0, 32'hC000_00A0, 8'h00, 64'h0);
    m_arready_i = 1'b1;
    @(posedge clk); #1;
    m_arready_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rready", 64'(m_rready_o), 64'(1));
    rst_ni = 1'b0;
    #1;
    chk("arst_flags", 64'({m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o,
                            m_rready_o, dev_data_ready_o, dev_err_o}), 64'(0));
    chk("arst_data", dev_data_o, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    run_vec(vt[8], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
